// File: rtl/pipe_skid_buffer.sv
// Two-entry skid buffer that decouples a valid/ready producer from its consumer; all outputs are registered.
// Optional synchronous flush port flush_i is present only when PIPE_SKID_FLUSH_EN is defined.
module pipe_skid_buffer #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             reset_n,
`ifdef PIPE_SKID_FLUSH_EN
    input  logic             flush_i,
`endif
    input  logic             s_valid_i,
    input  logic [WIDTH-1:0] s_data_i,
    output logic             s_ready_o,
    output logic             m_valid_o,
    output logic [WIDTH-1:0] m_data_o,
    input  logic             m_ready_i,
    output logic [1:0]       count_o
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_e;

    state_e           state_q;
    state_e           state_d;
    logic [WIDTH-1:0] main_q;
    logic [WIDTH-1:0] main_d;
    logic [WIDTH-1:0] skid_q;
    logic [WIDTH-1:0] skid_d;
    logic             s_ready_q;
    logic             m_valid_q;
    logic [1:0]       count_q;
    logic             push_s;
    logic             pop_s;
    logic             flush_s;

`ifdef PIPE_SKID_FLUSH_EN
    assign flush_s = flush_i;
`else
    assign flush_s = 1'b0;
`endif

    // Handshakes use the registered flags, so no input reaches an output combinationally.
    assign push_s = s_valid_i & s_ready_q;
    assign pop_s  = m_valid_q & m_ready_i;

    // Occupancy transitions and storage updates.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush_s) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (push_s) begin
                        state_d = ST_ONE;
                        main_d  = s_data_i;
                    end else begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_ONE: begin
                    if (push_s && pop_s) begin
                        state_d = ST_ONE;
                        main_d  = s_data_i;
                    end else if (push_s) begin
                        state_d = ST_FULL;
                        skid_d  = s_data_i;
                    end else if (pop_s) begin
                        state_d = ST_EMPTY;
                    end else begin
                        state_d = ST_ONE;
                    end
                end
                ST_FULL: begin
                    if (pop_s) begin
                        state_d = ST_ONE;
                        main_d  = skid_q;
                    end else begin
                        state_d = ST_FULL;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                end
            endcase
        end
    end

    // State, storage and output flags, all derived from the next state so outputs stay register-driven.
    always_ff @(posedge clk_i or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_EMPTY;
            main_q    <= {WIDTH{1'b0}};
            skid_q    <= {WIDTH{1'b0}};
            s_ready_q <= 1'b1;
            m_valid_q <= 1'b0;
            count_q   <= 2'd0;
        end else begin
            state_q   <= state_d;
            main_q    <= main_d;
            skid_q    <= skid_d;
            s_ready_q <= (state_d != ST_FULL);
            m_valid_q <= (state_d != ST_EMPTY);
            count_q   <= state_d;
        end
    end

    assign s_ready_o = s_ready_q;
    assign m_valid_o = m_valid_q;
    assign m_data_o  = main_q;
    assign count_o   = count_q;

endmodule

// File: tb/tb_pipe_skid_buffer.sv
// Bench for pipe_skid_buffer: directed scenarios plus random traffic against a queue-based reference model.
module tb_pipe_skid_buffer;
    localparam int W = 32;
`ifdef PIPE_SKID_FLUSH_EN
    localparam bit FLUSH_EN = 1'b1;
`else
    localparam bit FLUSH_EN = 1'b0;
`endif

    logic         clk_i = 1'b0;
    logic         reset_n;
    logic         s_valid_i;
    logic [W-1:0] s_data_i;
    logic         s_ready_o;
    logic         m_valid_o;
    logic [W-1:0] m_data_o;
    logic         m_ready_i;
    logic [1:0]   count_o;
`ifdef PIPE_SKID_FLUSH_EN
    logic         flush_i;
`endif

    int errors = 0;
    int checks = 0;
    logic [W-1:0] mq[$];

    pipe_skid_buffer #(.WIDTH(W)) dut (
        .clk_i     (clk_i),
        .reset_n   (reset_n),
`ifdef PIPE_SKID_FLUSH_EN
        .flush_i   (flush_i),
`endif
        .s_valid_i (s_valid_i),
        .s_data_i  (s_data_i),
        .s_ready_o (s_ready_o),
        .m_valid_o (m_valid_o),
        .m_data_o  (m_data_o),
        .m_ready_i (m_ready_i),
        .count_o   (count_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Outputs must match the FIFO model: occupancy is the queue length, head is the oldest item.
    task automatic model_cmp();
        chk("count", W'(count_o), W'(mq.size()));
        chk("m_valid", W'(m_valid_o), W'(mq.size() > 0));
        chk("s_ready", W'(s_ready_o), W'(mq.size() < 2));
        if (mq.size() > 0) chk("m_data", m_data_o, mq[0]);
    endtask

    // Apply one cycle of inputs (called just after a falling edge), update model at the rising edge, compare at the next falling edge.
    task automatic cycle(input logic sv, input logic [W-1:0] d, input logic mr, input logic fl);
        bit push;
        bit pop;
        s_valid_i = sv;
        s_data_i  = d;
        m_ready_i = mr;
`ifdef PIPE_SKID_FLUSH_EN
        flush_i   = fl;
`endif
        push = sv && (mq.size() < 2);
        pop  = (mq.size() > 0) && mr;
        @(posedge clk_i);
        if (fl && FLUSH_EN) begin
            mq.delete();
        end else begin
            if (pop) void'(mq.pop_front());
            if (push) mq.push_back(d);
        end
        @(negedge clk_i);
        model_cmp();
    endtask

    initial begin
        reset_n   = 1'b0;
        s_valid_i = 1'b1;
        s_data_i  = 32'hA5;
        m_ready_i = 1'b0;
`ifdef PIPE_SKID_FLUSH_EN
        flush_i   = 1'b0;
`endif
        repeat (2) @(negedge clk_i);
        chk("rst_m_valid", W'(m_valid_o), 32'd0);
        chk("rst_s_ready", W'(s_ready_o), 32'd1);
        chk("rst_count", W'(count_o), 32'd0);
        chk("rst_m_data", m_data_o, 32'd0);
        reset_n = 1'b1;

        // Single transfer held under backpressure
        cycle(1'b1, 32'h11, 1'b0, 1'b0);
        chk("single_data", m_data_o, 32'h11);
        chk("single_count", W'(count_o), 32'd1);
        repeat (3) cycle(1'b0, 32'h0, 1'b0, 1'b0);
        chk("single_hold", m_data_o, 32'h11);
        cycle(1'b0, 32'h0, 1'b1, 1'b0);

        // Fill, ignored offer, drain in order
        cycle(1'b1, 32'h01, 1'b0, 1'b0);
        cycle(1'b1, 32'h02, 1'b0, 1'b0);
        chk("fill_count", W'(count_o), 32'd2);
        chk("fill_s_ready", W'(s_ready_o), 32'd0);
        cycle(1'b1, 32'h03, 1'b0, 1'b0);
        chk("full_ignore", m_data_o, 32'h01);
        cycle(1'b0, 32'h0, 1'b1, 1'b0);
        chk("drain_first", m_data_o, 32'h02);
        cycle(1'b0, 32'h0, 1'b1, 1'b0);
        chk("drain_count", W'(count_o), 32'd0);

        // Back-to-back streaming
        for (int i = 1; i <= 8; i++) begin
            cycle(1'b1, W'(i), 1'b1, 1'b0);
            chk("stream_data", m_data_o, W'(i));
            chk("stream_count", W'(count_o), 32'd1);
        end
        cycle(1'b0, 32'h0, 1'b1, 1'b0);

        // Asynchronous reset while full
        cycle(1'b1, 32'h21, 1'b0, 1'b0);
        cycle(1'b1, 32'h22, 1'b0, 1'b0);
        #2 reset_n = 1'b0;
        #1;
        mq.delete();
        chk("arst_m_valid", W'(m_valid_o), 32'd0);
        chk("arst_s_ready", W'(s_ready_o), 32'd1);
        chk("arst_count", W'(count_o), 32'd0);
        chk("arst_m_data", m_data_o, 32'd0);
        @(negedge clk_i);
        reset_n = 1'b1;
        cycle(1'b1, 32'h7E, 1'b0, 1'b0);
        chk("post_rst_data", m_data_o, 32'h7E);
        cycle(1'b0, 32'h0, 1'b1, 1'b0);

`ifdef PIPE_SKID_FLUSH_EN
        cycle(1'b1, 32'h0A, 1'b0, 1'b0);
        cycle(1'b1, 32'h0B, 1'b0, 1'b0);
        cycle(1'b1, 32'h0C, 1'b0, 1'b1);
        chk("flush_count", W'(count_o), 32'd0);
        chk("flush_m_valid", W'(m_valid_o), 32'd0);
        repeat (2) cycle(1'b0, 32'h0, 1'b1, 1'b0);
`endif

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            cycle(1'($urandom_range(0, 1)), W'($urandom), 1'($urandom_range(0, 1)),
                  FLUSH_EN && ($urandom_range(0, 31) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
